// File: rtl/hilo_unit.sv
// -----------------------------------------------------------------------------
// hilo_unit
//
// Architectural HI/LO register pair with a two-slot (MEM, WB) in-flight write
// pipeline sitting right behind the EXE-stage multiply/divide unit. Writes are
// captured at EXE, travel through the MEM and WB slots, and only reach the
// architectural registers at WB so that an exception can still cancel them.
// MADD/MSUB accumulation happens on the MEM->WB step, where the base value is
// whatever the WB slot is about to commit (or the architectural value).
//
// Ports:
//   clk, rst             core clock, synchronous active-high reset
//   Pipe_Advance         pipeline moves this cycle
//   Flush                exception flush: kills EXE capture and the MEM slot
//   EXE_Finish           mult/div result valid (with EXE_MULTDIVtoHI/LO)
//   EXE_MultiExtendOp    00 write, 01 accumulate add, 10 accumulate subtract
//   EXE_IsMTHI/IsMTLO    MTHI/MTLO in EXE, data on EXE_MTData
//   EXE_ReadHILO         EXE instruction reads HI/LO
//   EXE_HI, EXE_LO       forwarded HI/LO as seen by EXE
//   HILO_Stall           EXE must hold, its value is still being accumulated
//   HI, LO               architectural registers
//
// Configuration macro: HILO_ACC_EN
//   defined   -> MADD/MSUB accumulate path and its stall are built
//   undefined -> EXE_MultiExtendOp ignored, every entry is a plain write,
//                HILO_Stall is tied low
// -----------------------------------------------------------------------------
module hilo_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        Pipe_Advance,
  input  logic        Flush,
  input  logic        EXE_Finish,
  input  logic [31:0] EXE_MULTDIVtoHI,
  input  logic [31:0] EXE_MULTDIVtoLO,
  input  logic [1:0]  EXE_MultiExtendOp,
  input  logic        EXE_IsMTHI,
  input  logic        EXE_IsMTLO,
  input  logic [31:0] EXE_MTData,
  input  logic        EXE_ReadHILO,
  output logic [31:0] EXE_HI,
  output logic [31:0] EXE_LO,
  output logic        HILO_Stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  // MEM slot: may still hold an unresolved accumulate request
  logic        r_memValid;
  logic        r_memWeHi;
  logic        r_memWeLo;
  logic [31:0] r_memHi;
  logic [31:0] r_memLo;

  // WB slot: always fully resolved, so it carries no op field
  logic        r_wbValid;
  logic        r_wbWeHi;
  logic        r_wbWeLo;
  logic [31:0] r_wbHi;
  logic [31:0] r_wbLo;

  // Architectural registers
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  // EXE capture candidate
  logic        w_capValid;
  logic        w_capWeHi;
  logic        w_capWeLo;
  logic [31:0] w_capHi;
  logic [31:0] w_capLo;

  // MEM entry as it will land in WB, and MEM forwarding eligibility
  logic [63:0] w_resolved;
  logic        w_memFwdHi;
  logic        w_memFwdLo;

  // Build the entry EXE would hand to MEM. A mult/div result wins over
  // MTHI/MTLO and writes both halves; MTHI and MTLO together write both
  // halves with the same rs value.
  always_comb begin
    w_capWeHi  = EXE_Finish || EXE_IsMTHI;
    w_capWeLo  = EXE_Finish || EXE_IsMTLO;
    w_capValid = !Flush && (EXE_Finish || EXE_IsMTHI || EXE_IsMTLO);
    w_capHi    = EXE_Finish ? EXE_MULTDIVtoHI : EXE_MTData;
    w_capLo    = EXE_Finish ? EXE_MULTDIVtoLO : EXE_MTData;
  end

`ifdef HILO_ACC_EN
  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_ADD   = 2'b01,
    OP_SUB   = 2'b10
  } acc_op_e;

  acc_op_e     r_memOp;
  acc_op_e     w_capOp;
  logic [63:0] w_base;

  // Only a mult/div result can accumulate; the reserved encoding 11 and all
  // MT* entries behave as a plain write.
  always_comb begin
    w_capOp = OP_WRITE;
    if (EXE_Finish) begin
      case (EXE_MultiExtendOp)
        2'b01:   w_capOp = OP_ADD;
        2'b10:   w_capOp = OP_SUB;
        default: w_capOp = OP_WRITE;
      endcase
    end
  end

  // The accumulate base is chosen per half: the WB slot is older than MEM
  // and commits on this same edge, so its written halves supersede the
  // architectural value. The 64-bit add/subtract wraps modulo 2^64.
  always_comb begin
    w_base[63:32] = (r_wbValid && r_wbWeHi) ? r_wbHi : r_hi;
    w_base[31:0]  = (r_wbValid && r_wbWeLo) ? r_wbLo : r_lo;
    case (r_memOp)
      OP_ADD:  w_resolved = w_base + {r_memHi, r_memLo};
      OP_SUB:  w_resolved = w_base - {r_memHi, r_memLo};
      default: w_resolved = {r_memHi, r_memLo};
    endcase
  end

  // An accumulate in MEM has no usable value yet: readers must stall and
  // forwarding skips past it to the older WB/architectural value.
  assign HILO_Stall = EXE_ReadHILO && r_memValid && (r_memOp != OP_WRITE);
  assign w_memFwdHi = r_memValid && r_memWeHi && (r_memOp == OP_WRITE);
  assign w_memFwdLo = r_memValid && r_memWeLo && (r_memOp == OP_WRITE);
`else
  logic w_unusedIn;

  // Without the accumulate path every MEM entry already holds final data.
  assign w_unusedIn = ^{EXE_MultiExtendOp, EXE_ReadHILO};
  assign w_resolved = {r_memHi, r_memLo};
  assign HILO_Stall = 1'b0;
  assign w_memFwdHi = r_memValid && r_memWeHi;
  assign w_memFwdLo = r_memValid && r_memWeLo;
`endif

  // Forwarding priority per half: MEM slot, then WB slot, then architectural.
  assign EXE_HI = w_memFwdHi ? r_memHi :
                  (r_wbValid && r_wbWeHi) ? r_wbHi : r_hi;
  assign EXE_LO = w_memFwdLo ? r_memLo :
                  (r_wbValid && r_wbWeLo) ? r_wbLo : r_lo;

  assign HI = r_hi;
  assign LO = r_lo;

  // Slot and architectural state. Nothing moves unless the pipe advances.
  // On a flush the WB entry still commits (it is older than the excepting
  // instruction) while the MEM entry and the EXE capture are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi       <= '0;
      r_lo       <= '0;
      r_memValid <= 1'b0;
      r_memWeHi  <= 1'b0;
      r_memWeLo  <= 1'b0;
      r_memHi    <= '0;
      r_memLo    <= '0;
      r_wbValid  <= 1'b0;
      r_wbWeHi   <= 1'b0;
      r_wbWeLo   <= 1'b0;
      r_wbHi     <= '0;
      r_wbLo     <= '0;
`ifdef HILO_ACC_EN
      r_memOp    <= OP_WRITE;
`endif
    end else if (Pipe_Advance) begin
      if (r_wbValid && r_wbWeHi) r_hi <= r_wbHi;
      if (r_wbValid && r_wbWeLo) r_lo <= r_wbLo;

      r_wbValid  <= r_memValid && !Flush;
      r_wbWeHi   <= r_memWeHi;
      r_wbWeLo   <= r_memWeLo;
      r_wbHi     <= w_resolved[63:32];
      r_wbLo     <= w_resolved[31:0];

      r_memValid <= w_capValid;
      r_memWeHi  <= w_capWeHi;
      r_memWeLo  <= w_capWeLo;
      r_memHi    <= w_capHi;
      r_memLo    <= w_capLo;
`ifdef HILO_ACC_EN
      r_memOp    <= w_capOp;
`endif
    end
  end

endmodule

// File: tb/tb_hilo_unit.sv
// -----------------------------------------------------------------------------
// tb_hilo_unit
//
// Self-checking bench for hilo_unit. Directed scenarios compare against
// hand-derived constants; the random scenario compares every cycle against a
// program-order model: a queue of in-flight writes, where an accumulate is
// resolved against the HI:LO value that all older writes produce.
// Honours HILO_ACC_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_hilo_unit;

`ifdef HILO_ACC_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        Pipe_Advance;
  logic        Flush;
  logic        EXE_Finish;
  logic [31:0] EXE_MULTDIVtoHI;
  logic [31:0] EXE_MULTDIVtoLO;
  logic [1:0]  EXE_MultiExtendOp;
  logic        EXE_IsMTHI;
  logic        EXE_IsMTLO;
  logic [31:0] EXE_MTData;
  logic        EXE_ReadHILO;
  logic [31:0] EXE_HI;
  logic [31:0] EXE_LO;
  logic        HILO_Stall;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int errors = 0;

  hilo_unit dut (
    .clk               (clk),
    .rst               (rst),
    .Pipe_Advance      (Pipe_Advance),
    .Flush             (Flush),
    .EXE_Finish        (EXE_Finish),
    .EXE_MULTDIVtoHI   (EXE_MULTDIVtoHI),
    .EXE_MULTDIVtoLO   (EXE_MULTDIVtoLO),
    .EXE_MultiExtendOp (EXE_MultiExtendOp),
    .EXE_IsMTHI        (EXE_IsMTHI),
    .EXE_IsMTLO        (EXE_IsMTLO),
    .EXE_MTData        (EXE_MTData),
    .EXE_ReadHILO      (EXE_ReadHILO),
    .EXE_HI            (EXE_HI),
    .EXE_LO            (EXE_LO),
    .HILO_Stall        (HILO_Stall),
    .HI                (HI),
    .LO                (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: in-flight writes in program order (oldest first).
  // stage 0 = just captured, stage 1 = next to commit.
  typedef struct {
    bit        weHi;
    bit        weLo;
    bit [1:0]  op;
    bit [63:0] val;
    int        stage;
  } ent_t;

  ent_t      mq[$];
  bit [63:0] mArch;

  // Advance the model by one clock edge using the inputs present at that edge.
  function automatic void modelEdge();
    ent_t nq[$];
    ent_t e;
    if (rst) begin
      mq.delete();
      mArch = '0;
      return;
    end
    if (!Pipe_Advance) return;
    foreach (mq[i]) begin
      e = mq[i];
      if (e.stage == 1) begin
        if (e.weHi) mArch[63:32] = e.val[63:32];
        if (e.weLo) mArch[31:0]  = e.val[31:0];
      end else if (!Flush) begin
        // Everything older has committed by now, so mArch is the base.
        if (e.op == 2'd1)      e.val = mArch + e.val;
        else if (e.op == 2'd2) e.val = mArch - e.val;
        e.op    = 2'd0;
        e.stage = 1;
        nq.push_back(e);
      end
    end
    if (!Flush && (EXE_Finish || EXE_IsMTHI || EXE_IsMTLO)) begin
      e.weHi  = EXE_Finish || EXE_IsMTHI;
      e.weLo  = EXE_Finish || EXE_IsMTLO;
      e.val   = EXE_Finish ? {EXE_MULTDIVtoHI, EXE_MULTDIVtoLO}
                           : {EXE_MTData, EXE_MTData};
      e.op    = (ACC && EXE_Finish && EXE_MultiExtendOp != 2'd3) ? EXE_MultiExtendOp : 2'd0;
      e.stage = 0;
      nq.push_back(e);
    end
    mq = nq;
  endfunction

  // Newest in-flight value of a half that is already known, else architectural.
  function automatic bit [31:0] expFwd(bit hiHalf);
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if ((hiHalf ? mq[i].weHi : mq[i].weLo) && !(mq[i].stage == 0 && mq[i].op != 2'd0))
        return hiHalf ? mq[i].val[63:32] : mq[i].val[31:0];
    end
    return hiHalf ? mArch[63:32] : mArch[31:0];
  endfunction

  function automatic bit expStall();
    bit pending = 1'b0;
    foreach (mq[i]) if (mq[i].stage == 0 && mq[i].op != 2'd0) pending = 1'b1;
    return EXE_ReadHILO && pending;
  endfunction

  // Idle inputs with the pipe advancing.
  task automatic clearInputs();
    rst               = 1'b0;
    Pipe_Advance      = 1'b1;
    Flush             = 1'b0;
    EXE_Finish        = 1'b0;
    EXE_MULTDIVtoHI   = '0;
    EXE_MULTDIVtoLO   = '0;
    EXE_MultiExtendOp = 2'd0;
    EXE_IsMTHI        = 1'b0;
    EXE_IsMTLO        = 1'b0;
    EXE_MTData        = '0;
    EXE_ReadHILO      = 1'b0;
  endtask

  // Take one clock edge with the current inputs, then settle past it.
  task automatic applyStimulus();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic finishOp(input logic [31:0] hi, input logic [31:0] lo, input logic [1:0] op);
    clearInputs();
    EXE_Finish        = 1'b1;
    EXE_MULTDIVtoHI   = hi;
    EXE_MULTDIVtoLO   = lo;
    EXE_MultiExtendOp = op;
  endtask

  task automatic test_reset();
    rst               = 1'b1;
    Pipe_Advance      = 1'($urandom);
    Flush             = 1'($urandom);
    EXE_Finish        = 1'($urandom);
    EXE_MULTDIVtoHI   = $urandom;
    EXE_MULTDIVtoLO   = $urandom;
    EXE_MultiExtendOp = 2'($urandom);
    EXE_IsMTHI        = 1'($urandom);
    EXE_IsMTLO        = 1'($urandom);
    EXE_MTData        = $urandom;
    EXE_ReadHILO      = 1'($urandom);
    applyStimulus();
    clearInputs();
    EXE_ReadHILO = 1'b1;
    #1;
    checks++; if (HI !== 32'h0) begin errors++; $display("[TB] FAIL reset_hi: got %h want %h", HI, 32'h0); end
    checks++; if (LO !== 32'h0) begin errors++; $display("[TB] FAIL reset_lo: got %h want %h", LO, 32'h0); end
    checks++; if (EXE_HI !== 32'h0) begin errors++; $display("[TB] FAIL reset_exe_hi: got %h want %h", EXE_HI, 32'h0); end
    checks++; if (EXE_LO !== 32'h0) begin errors++; $display("[TB] FAIL reset_exe_lo: got %h want %h", EXE_LO, 32'h0); end
    checks++; if (HILO_Stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b want 0", HILO_Stall); end
  endtask

  task automatic test_mult();
    finishOp(32'h1, 32'h2, 2'd0);
    applyStimulus();
    clearInputs();
    #1;
    checks++; if (EXE_HI !== 32'h1 || EXE_LO !== 32'h2) begin errors++; $display("[TB] FAIL mult_fwd_mem: got %h/%h want 1/2", EXE_HI, EXE_LO); end
    checks++; if (HI !== 32'h0) begin errors++; $display("[TB] FAIL mult_arch_early: got %h want 0", HI); end
    applyStimulus();
    checks++; if (EXE_HI !== 32'h1 || EXE_LO !== 32'h2) begin errors++; $display("[TB] FAIL mult_fwd_wb: got %h/%h want 1/2", EXE_HI, EXE_LO); end
    checks++; if (HI !== 32'h0 || LO !== 32'h0) begin errors++; $display("[TB] FAIL mult_arch_wb: got %h/%h want 0/0", HI, LO); end
    applyStimulus();
    checks++; if (HI !== 32'h1 || LO !== 32'h2) begin errors++; $display("[TB] FAIL mult_commit: got %h/%h want 1/2", HI, LO); end
  endtask

  task automatic test_mt_both();
    clearInputs();
    EXE_IsMTHI = 1'b1;
    EXE_IsMTLO = 1'b1;
    EXE_MTData = 32'h5A5A_C3C3;
    applyStimulus();
    clearInputs();
    applyStimulus();
    applyStimulus();
    checks++; if (HI !== 32'h5A5A_C3C3 || LO !== 32'h5A5A_C3C3) begin errors++; $display("[TB] FAIL mt_both: got %h/%h want 5a5ac3c3/5a5ac3c3", HI, LO); end
  endtask

  task automatic test_madd_carry();
    clearInputs();
    EXE_IsMTHI = 1'b1;
    EXE_MTData = 32'h0;
    applyStimulus();
    clearInputs();
    EXE_IsMTLO = 1'b1;
    EXE_MTData = 32'hFFFF_FFFF;
    applyStimulus();
    finishOp(32'h0, 32'h1, 2'd1);
    applyStimulus();
    clearInputs();
    applyStimulus();
    applyStimulus();
    checks++; if (HI !== (ACC ? 32'h1 : 32'h0) || LO !== (ACC ? 32'h0 : 32'h1)) begin
      errors++; $display("[TB] FAIL madd_carry: got %h/%h want %h/%h", HI, LO, ACC ? 32'h1 : 32'h0, ACC ? 32'h0 : 32'h1);
    end
  endtask

  task automatic test_msub_borrow();
    clearInputs();
    rst = 1'b1;
    applyStimulus();
    finishOp(32'h0, 32'h1, 2'd2);
    applyStimulus();
    clearInputs();
    applyStimulus();
    applyStimulus();
    checks++; if (HI !== (ACC ? 32'hFFFF_FFFF : 32'h0) || LO !== (ACC ? 32'hFFFF_FFFF : 32'h1)) begin
      errors++; $display("[TB] FAIL msub_borrow: got %h/%h", HI, LO);
    end
  endtask

  task automatic test_acc_stall();
    clearInputs();
    EXE_IsMTHI = 1'b1;
    EXE_MTData = 32'h10;
    applyStimulus();
    clearInputs();
    EXE_IsMTLO = 1'b1;
    EXE_MTData = 32'h20;
    applyStimulus();
    clearInputs();
    applyStimulus();
    applyStimulus();
    finishOp(32'h2, 32'h3, 2'd1);
    applyStimulus();
    clearInputs();
    EXE_ReadHILO = 1'b1;
    #1;
    checks++; if (HILO_Stall !== ACC) begin errors++; $display("[TB] FAIL stall_assert: got %b want %b", HILO_Stall, ACC); end
    applyStimulus();
    checks++; if (HILO_Stall !== 1'b0) begin errors++; $display("[TB] FAIL stall_release: got %b want 0", HILO_Stall); end
    checks++; if (EXE_HI !== (ACC ? 32'h12 : 32'h2) || EXE_LO !== (ACC ? 32'h23 : 32'h3)) begin
      errors++; $display("[TB] FAIL stall_fwd: got %h/%h", EXE_HI, EXE_LO);
    end
    clearInputs();
    applyStimulus();
    applyStimulus();
  endtask

  task automatic test_back_to_back();
    // Architectural value left by the previous scenario: 12/23 or 2/3.
    finishOp(32'h0, 32'h5, 2'd1);
    applyStimulus();
    finishOp(32'h0, 32'h7, 2'd1);
    #1;
    checks++; if (HILO_Stall !== 1'b0) begin errors++; $display("[TB] FAIL b2b_nostall: got %b want 0", HILO_Stall); end
    applyStimulus();
    clearInputs();
    applyStimulus();
    checks++; if (HI !== (ACC ? 32'h12 : 32'h0) || LO !== (ACC ? 32'h28 : 32'h5)) begin
      errors++; $display("[TB] FAIL b2b_first: got %h/%h", HI, LO);
    end
    applyStimulus();
    checks++; if (HI !== (ACC ? 32'h12 : 32'h0) || LO !== (ACC ? 32'h2F : 32'h7)) begin
      errors++; $display("[TB] FAIL b2b_second: got %h/%h", HI, LO);
    end
  endtask

  task automatic test_flush();
    clearInputs();
    rst = 1'b1;
    applyStimulus();
    clearInputs();
    EXE_IsMTHI = 1'b1;
    EXE_MTData = 32'hAAAA_5555;
    applyStimulus();
    clearInputs();
    EXE_IsMTLO = 1'b1;
    EXE_MTData = 32'h1234_5678;
    applyStimulus();
    finishOp(32'hDEAD_0000, 32'h0000_BEEF, 2'd0);
    Flush = 1'b1;
    applyStimulus();
    clearInputs();
    #1;
    checks++; if (HI !== 32'hAAAA_5555 || LO !== 32'h0) begin errors++; $display("[TB] FAIL flush_commit: got %h/%h want aaaa5555/0", HI, LO); end
    checks++; if (EXE_HI !== 32'hAAAA_5555 || EXE_LO !== 32'h0) begin errors++; $display("[TB] FAIL flush_fwd: got %h/%h want aaaa5555/0", EXE_HI, EXE_LO); end
    applyStimulus();
    applyStimulus();
    checks++; if (HI !== 32'hAAAA_5555 || LO !== 32'h0) begin errors++; $display("[TB] FAIL flush_drain: got %h/%h want aaaa5555/0", HI, LO); end
  endtask

  task automatic test_hold();
    finishOp(32'h11, 32'h22, 2'd0);
    Pipe_Advance = 1'b0;
    applyStimulus();
    checks++; if (EXE_HI !== 32'hAAAA_5555) begin errors++; $display("[TB] FAIL hold_nocapture: got %h want aaaa5555", EXE_HI); end
    Pipe_Advance = 1'b1;
    applyStimulus();
    clearInputs();
    Pipe_Advance = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus();
    checks++; if (HI !== 32'hAAAA_5555 || EXE_HI !== 32'h11 || EXE_LO !== 32'h22) begin
      errors++; $display("[TB] FAIL hold_frozen: got HI %h fwd %h/%h", HI, EXE_HI, EXE_LO);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst               = ($urandom_range(0, 49) == 0);
      Pipe_Advance      = ($urandom_range(0, 3) != 0);
      Flush             = ($urandom_range(0, 11) == 0);
      EXE_Finish        = ($urandom_range(0, 2) == 0);
      EXE_MULTDIVtoHI   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      EXE_MULTDIVtoLO   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      EXE_MultiExtendOp = 2'($urandom);
      EXE_IsMTHI        = ($urandom_range(0, 3) == 0);
      EXE_IsMTLO        = ($urandom_range(0, 3) == 0);
      EXE_MTData        = $urandom;
      EXE_ReadHILO      = ($urandom_range(0, 2) == 0);
      #1;
      checks++; if (HI !== mArch[63:32]) begin errors++; $display("[TB] FAIL rand_hi cyc %0d: got %h want %h", n, HI, mArch[63:32]); end
      checks++; if (LO !== mArch[31:0]) begin errors++; $display("[TB] FAIL rand_lo cyc %0d: got %h want %h", n, LO, mArch[31:0]); end
      checks++; if (EXE_HI !== expFwd(1'b1)) begin errors++; $display("[TB] FAIL rand_exe_hi cyc %0d: got %h want %h", n, EXE_HI, expFwd(1'b1)); end
      checks++; if (EXE_LO !== expFwd(1'b0)) begin errors++; $display("[TB] FAIL rand_exe_lo cyc %0d: got %h want %h", n, EXE_LO, expFwd(1'b0)); end
      checks++; if (HILO_Stall !== expStall()) begin errors++; $display("[TB] FAIL rand_stall cyc %0d: got %b want %b", n, HILO_Stall, expStall()); end
      applyStimulus();
    end
  endtask

  initial begin
    clearInputs();
    @(negedge clk);
    test_reset();
    test_mult();
    test_mt_both();
    test_madd_carry();
    test_msub_borrow();
    test_acc_stall();
    test_back_to_back();
    test_flush();
    test_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
